scoreboard_counting: RTL and testbench

//  Register-dependency scoreboard for the vanilla core, with per-register pending-write counters.

---
 rtl/scoreboard_counting_pkg.sv | 13 +
 rtl/scoreboard_entry_counter.sv | 54 +++++
 rtl/scoreboard_counting.sv | 101 ++++++++++
 tb/tb_scoreboard_counting.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_counting_pkg.sv
// Shared vanilla-core definitions used by the counting scoreboard.
package scoreboard_counting_pkg;

    // Width of an RV32 architectural register index.
    localparam int RV32_reg_addr_width_gp = 5;

    // Default pending-write counter width (up to 3 outstanding writes per register).
    localparam int count_width_default_gp = 2;

    // Architectural register identifier.
    typedef logic [RV32_reg_addr_width_gp-1:0] reg_id_t;

endpackage

// File: rtl/scoreboard_entry_counter.sv
// One scoreboard entry: a saturating pending-write counter.
// It reports the count net of same-cycle clears and flags underflow/overflow events.
module scoreboard_entry_counter #(
    parameter int count_width_p = 2,
    parameter int dec_width_p   = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     inc_i,
    input  logic [dec_width_p-1:0]   dec_i,
    output logic [count_width_p-1:0] count_o,
    output logic [count_width_p-1:0] eff_o,
    output logic                     underflow_o,
    output logic                     overflow_o
);

    // One extra bit over the wider operand so that count+inc and the compares cannot wrap.
    localparam int ext_w_lp = ((count_width_p > dec_width_p) ? count_width_p : dec_width_p) + 1;
    localparam logic [count_width_p-1:0] max_lp = '1;

    logic [count_width_p-1:0] count_d, count_q;
    logic [ext_w_lp-1:0]      count_ext, dec_ext, sum_ext;

    // Next-state: count + inc - dec, floored at 0 and held at max on an unbalanced overflow.
    always_comb begin
        count_ext   = ext_w_lp'(count_q);
        dec_ext     = ext_w_lp'(dec_i);
        sum_ext     = count_ext + ext_w_lp'(inc_i);
        underflow_o = (dec_ext > sum_ext);
        overflow_o  = (count_q == max_lp) && inc_i && (dec_i == '0);
        count_d     = count_q;
        if (underflow_o) begin
            count_d = '0;
        end else if (overflow_o) begin
            count_d = max_lp;
        end else begin
            count_d = count_width_p'(sum_ext - dec_ext);
        end
        // A same-cycle score does not count toward eff; same-cycle clears do.
        eff_o = (count_ext > dec_ext) ? count_width_p'(count_ext - dec_ext) : '0;
    end

    // Counter register; reset drops all outstanding writes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/scoreboard_counting.sv
// Register-dependency scoreboard with per-register pending-write counters.
// Scored at issue, cleared from the writeback channels, drives the ID stall.
module scoreboard_counting
    import scoreboard_counting_pkg::*;
#(
    parameter int els_p         = 32,
    parameter int id_width_p    = RV32_reg_addr_width_gp,
    parameter int num_src_p     = 3,
    parameter int num_clear_p   = 2,
    parameter int count_width_p = count_width_default_gp,
    parameter int zero_reg_p    = 1,
    parameter int allow_waw_p   = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_src_p-1:0]              src_v_i,
    input  logic [num_src_p*id_width_p-1:0]   src_id_i,
    input  logic                              dest_v_i,
    input  logic [id_width_p-1:0]             dest_id_i,
    input  logic                              score_i,
    input  logic [num_clear_p-1:0]            clear_i,
    input  logic [num_clear_p*id_width_p-1:0] clear_id_i,
    output logic                              dependency_o,
    output logic [num_src_p-1:0]              src_busy_o,
    output logic                              pending_any_o,
    output logic                              error_o
);

    localparam int dec_width_lp = $clog2(num_clear_p + 1);
    localparam logic [count_width_p-1:0] max_lp = '1;

    logic [els_p-1:0]                    inc;
    logic [dec_width_lp-1:0]             dec       [els_p];
    logic [els_p-1:0][count_width_p-1:0] count;
    logic [count_width_p-1:0]            eff       [els_p];
    logic [els_p-1:0]                    underflow;
    logic [els_p-1:0]                    overflow;
    logic [count_width_p-1:0]            eff_dest;
    logic                                dest_busy;
    logic                                error_d, error_q;

    // Per-entry score decode and popcount of matching clear channels.
    always_comb begin
        for (int e = 0; e < els_p; e++) begin
            inc[e] = score_i && (dest_id_i == id_width_p'(e)) && !((zero_reg_p != 0) && (e == 0));
            dec[e] = '0;
            for (int k = 0; k < num_clear_p; k++) begin
                if (clear_i[k] && (clear_id_i[k*id_width_p +: id_width_p] == id_width_p'(e))) begin
                    dec[e] = dec[e] + dec_width_lp'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < els_p; g++) begin : g_entry
        scoreboard_entry_counter #(
            .count_width_p(count_width_p),
            .dec_width_p  (dec_width_lp)
        ) u_entry (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .inc_i      (inc[g]),
            .dec_i      (dec[g]),
            .count_o    (count[g]),
            .eff_o      (eff[g]),
            .underflow_o(underflow[g]),
            .overflow_o (overflow[g])
        );
    end

    // Source and destination read muxes over the effective counts; combine into the stall.
    always_comb begin
        logic [id_width_p-1:0] sid;
        sid = '0;
        for (int i = 0; i < num_src_p; i++) begin
            sid           = src_id_i[i*id_width_p +: id_width_p];
            src_busy_o[i] = src_v_i[i] && (eff[sid] != '0) && !((zero_reg_p != 0) && (sid == '0));
        end
        eff_dest = eff[dest_id_i];
        if (allow_waw_p != 0) begin
            dest_busy = dest_v_i && (eff_dest == max_lp);
        end else begin
            dest_busy = dest_v_i && (eff_dest != '0);
        end
        dependency_o = (|src_busy_o) || dest_busy;
        error_d      = error_q || (|underflow) || (|overflow);
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign pending_any_o = |count;
    assign error_o       = error_q;

endmodule

// File: tb/tb_scoreboard_counting.sv
// Scoreboard-style bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Two instances share the stimulus: default (no WAW tolerance) and allow_waw_p=1.
module tb_scoreboard_counting;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [2:0]  src_v;
    logic [14:0] src_id;
    logic        dest_v;
    logic [4:0]  dest_id;
    logic        score;
    logic [1:0]  clear;
    logic [9:0]  clear_id;

    logic        dep_a, pend_a, err_a;
    logic [2:0]  sb_a;
    logic        dep_w, pend_w, err_w;
    logic [2:0]  sb_w;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] sb;
        logic       dep_a;
        logic       dep_w;
        logic       pend;
        logic       err;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    scoreboard_counting #(.allow_waw_p(0)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .src_v_i(src_v), .src_id_i(src_id),
        .dest_v_i(dest_v), .dest_id_i(dest_id), .score_i(score),
        .clear_i(clear), .clear_id_i(clear_id),
        .dependency_o(dep_a), .src_busy_o(sb_a), .pending_any_o(pend_a), .error_o(err_a)
    );

    scoreboard_counting #(.allow_waw_p(1)) dut_w (
        .clk_i(clk), .reset_i(reset_i), .src_v_i(src_v), .src_id_i(src_id),
        .dest_v_i(dest_v), .dest_id_i(dest_id), .score_i(score),
        .clear_i(clear), .clear_id_i(clear_id),
        .dependency_o(dep_w), .src_busy_o(sb_w), .pending_any_o(pend_w), .error_o(err_w)
    );

    task automatic cmp(input string nm, input string fld, input logic [2:0] act, input logic [2:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %0b expected %0b", nm, fld, act, req);
        end
    endtask

    // Monitor: one expected record per cycle in which stimulus issued one.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "src_busy_a", sb_a, e.sb);
            cmp(e.name, "src_busy_w", sb_w, e.sb);
            cmp(e.name, "dep_a", {2'b00, dep_a}, {2'b00, e.dep_a});
            cmp(e.name, "dep_w", {2'b00, dep_w}, {2'b00, e.dep_w});
            cmp(e.name, "pending_a", {2'b00, pend_a}, {2'b00, e.pend});
            cmp(e.name, "pending_w", {2'b00, pend_w}, {2'b00, e.pend});
            cmp(e.name, "error_a", {2'b00, err_a}, {2'b00, e.err});
            cmp(e.name, "error_w", {2'b00, err_w}, {2'b00, e.err});
        end
    end

    task automatic idle();
        src_v = '0; src_id = '0; dest_v = 1'b0; dest_id = '0;
        score = 1'b0; clear = '0; clear_id = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic src(input int i, input logic [4:0] id);
        src_v[i] = 1'b1;
        src_id[i*5 +: 5] = id;
    endtask

    task automatic clr(input int k, input logic [4:0] id);
        clear[k] = 1'b1;
        clear_id[k*5 +: 5] = id;
    endtask

    task automatic scr(input logic [4:0] id);
        score = 1'b1;
        dest_id = id;
    endtask

    task automatic dst(input logic [4:0] id);
        dest_v = 1'b1;
        dest_id = id;
    endtask

    task automatic expect_o(input logic [2:0] sb, input logic da, input logic dw,
                            input logic pend, input logic err, input string nm);
        exp_t e;
        e.sb = sb; e.dep_a = da; e.dep_w = dw; e.pend = pend; e.err = err; e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_o(3'b000, 0, 0, 0, 0, "reset");
        next(); reset_i = 1'b0; src(0, 5'd5);
        expect_o(3'b000, 0, 0, 0, 0, "t1_idle_src_r5");

        // Test 2: score, busy, same-cycle clear.
        next(); scr(5'd5);
        expect_o(3'b000, 0, 0, 0, 0, "t2_score_cycle");
        next(); src(0, 5'd5);
        expect_o(3'b001, 1, 1, 1, 0, "t2_src_busy");
        next(); dst(5'd5);
        expect_o(3'b000, 1, 0, 1, 0, "t2_dest_waw");
        next(); src(0, 5'd5); clr(1, 5'd5);
        expect_o(3'b000, 0, 0, 1, 0, "t2_same_cycle_clear");
        next(); src(0, 5'd5);
        expect_o(3'b000, 0, 0, 0, 0, "t2_drained");

        // Test 3: saturation with WAW tolerance, overflow.
        next(); scr(5'd7);
        expect_o(3'b000, 0, 0, 0, 0, "t3_score1");
        next(); scr(5'd7);
        expect_o(3'b000, 0, 0, 1, 0, "t3_score2");
        next(); scr(5'd7);
        expect_o(3'b000, 0, 0, 1, 0, "t3_score3");
        next(); dst(5'd7);
        expect_o(3'b000, 1, 1, 1, 0, "t3_dest_saturated");
        next(); dst(5'd7); clr(0, 5'd7);
        expect_o(3'b000, 1, 0, 1, 0, "t3_clear_unblocks");
        next(); scr(5'd7);
        expect_o(3'b000, 0, 0, 1, 0, "t3_rescore_to_max");
        next(); scr(5'd7); dst(5'd7);
        expect_o(3'b000, 1, 1, 1, 0, "t3_overflow_cycle");
        next(); dst(5'd7);
        expect_o(3'b000, 1, 1, 1, 1, "t3_overflow_sticky");
        next(); dst(5'd7); clr(0, 5'd7);
        expect_o(3'b000, 1, 0, 1, 1, "t3_held_at_max");
        next(); reset_i = 1'b1;
        expect_o(3'b000, 0, 0, 0, 0, "t3_reset");
        next(); reset_i = 1'b0;

        // Test 4: double clear, then underflow.
        scr(5'd3);
        expect_o(3'b000, 0, 0, 0, 0, "t4_score1");
        next(); scr(5'd3);
        expect_o(3'b000, 0, 0, 1, 0, "t4_score2");
        next(); src(0, 5'd3); clr(0, 5'd3); clr(1, 5'd3);
        expect_o(3'b000, 0, 0, 1, 0, "t4_double_clear");
        next(); src(0, 5'd3);
        expect_o(3'b000, 0, 0, 0, 0, "t4_zero_no_error");
        next(); scr(5'd3);
        expect_o(3'b000, 0, 0, 0, 0, "t4_score_once");
        next(); clr(0, 5'd3); clr(1, 5'd3);
        expect_o(3'b000, 0, 0, 1, 0, "t4_underflow_cycle");
        next(); src(0, 5'd3);
        expect_o(3'b000, 0, 0, 0, 1, "t4_underflow_error");
        next(); reset_i = 1'b1;
        expect_o(3'b000, 0, 0, 0, 0, "t4_reset");
        next(); reset_i = 1'b0;

        // Test 5: hardwired zero register.
        scr(5'd0);
        expect_o(3'b000, 0, 0, 0, 0, "t5_score_r0");
        next(); src(0, 5'd0); dst(5'd0);
        expect_o(3'b000, 0, 0, 0, 0, "t5_r0_never_busy");

        // Test 6: score and clear net out, multi-source, async reset.
        next(); scr(5'd9);
        expect_o(3'b000, 0, 0, 0, 0, "t6_score");
        next(); scr(5'd9); clr(0, 5'd9); src(0, 5'd9); src(1, 5'd4); src(2, 5'd9);
        expect_o(3'b000, 0, 0, 1, 0, "t6_score_and_clear");
        next(); src(0, 5'd9); src(1, 5'd4); src(2, 5'd9);
        expect_o(3'b101, 1, 1, 1, 0, "t6_counter_held");
        next(); src(0, 5'd9); clr(0, 5'd12);
        expect_o(3'b001, 1, 1, 1, 0, "t6_underflow_r12");
        next(); src(0, 5'd9);
        expect_o(3'b001, 1, 1, 1, 1, "t6_error_set");
        next(); src(0, 5'd9); reset_i = 1'b1;
        expect_o(3'b000, 0, 0, 0, 0, "t6_async_reset");
        next(); reset_i = 1'b0; src(0, 5'd9);
        expect_o(3'b000, 0, 0, 0, 0, "t6_after_reset");

        next();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
